gate_scheduler: RTL and testbench

Shared-barrier scheduler for the car parking system. One physical gate serves both the entrance lane and the exit lane. This block arbitrates between the two lanes with round-robin priority and holds each grant until the vehicle passes or a timeout expires. It maintains the lot occupancy count, refuses entry when the lot is full and refuses exit when it is empty. It sits between the password/sensor front end and the gate actuator and 7-segment occupancy display.

---
 rtl/gate_scheduler.sv | 114 +++++++++++
 tb/tb_gate_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gate_scheduler.sv
// Shared-barrier scheduler: round-robin arbitration between entrance and exit lanes,
// grant held until pass or timeout, followed by a closed guard interval; tracks lot occupancy.
module gate_scheduler #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int CLOSE_CYCLES = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ent_req,
  input  logic             ext_req,
  input  logic             pass,
  output logic             ent_grant,
  output logic             ext_grant,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             timeout_err
);
  localparam int TMAX = (TIMEOUT > CLOSE_CYCLES) ? TIMEOUT : CLOSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, SERVE, CLOSE} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [CNT_W-1:0] occ_n;
  logic             last_served, last_n;   // 0 = entrance, 1 = exit
  logic             ent_g_n, ext_g_n, open_n, terr_n;
  logic             ent_ok, ext_ok;

  assign full   = (occupancy == CNT_W'(CAPACITY));
  assign empty  = (occupancy == '0);
  assign ent_ok = ent_req & ~full;
  assign ext_ok = ext_req & ~empty;

  always_comb begin
    state_n = state;
    timer_n = timer;
    occ_n   = occupancy;
    last_n  = last_served;
    ent_g_n = 1'b0;
    ext_g_n = 1'b0;
    open_n  = 1'b0;
    terr_n  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the lane not served last wins
        if (ent_ok && (!ext_ok || last_served)) begin
          ent_g_n = 1'b1;
          open_n  = 1'b1;
          state_n = SERVE;
          timer_n = '0;
        end else if (ext_ok) begin
          ext_g_n = 1'b1;
          open_n  = 1'b1;
          state_n = SERVE;
          timer_n = '0;
        end
      end
      SERVE: begin
        if (pass) begin
          occ_n   = ent_grant ? occupancy + CNT_W'(1) : occupancy - CNT_W'(1);
          last_n  = ext_grant;
          state_n = CLOSE;
          timer_n = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          terr_n  = 1'b1;
          last_n  = ext_grant;
          state_n = CLOSE;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
          ent_g_n = ent_grant;
          ext_g_n = ext_grant;
          open_n  = 1'b1;
        end
      end
      CLOSE: begin
        if (timer == TW'(CLOSE_CYCLES - 1)) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      occupancy   <= '0;
      last_served <= 1'b1;
      ent_grant   <= 1'b0;
      ext_grant   <= 1'b0;
      gate_open   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      occupancy   <= occ_n;
      last_served <= last_n;
      ent_grant   <= ent_g_n;
      ext_grant   <= ext_g_n;
      gate_open   <= open_n;
      timeout_err <= terr_n;
    end
  end
endmodule

// File: tb/tb_gate_scheduler.sv
// Bench for gate_scheduler: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model of the lot and gate.
module tb_gate_scheduler;
  localparam int CAP = 2, CW = 2, CC = 4, TO = 8;

  logic          clk = 1'b0, reset_n = 1'b0, ent_req = 1'b0, ext_req = 1'b0, pass = 1'b0;
  logic          ent_grant, ext_grant, gate_open, full, empty, timeout_err;
  logic [CW-1:0] occupancy;

  gate_scheduler #(.CAPACITY(CAP), .CNT_W(CW), .CLOSE_CYCLES(CC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ent_req(ent_req), .ext_req(ext_req), .pass(pass),
    .ent_grant(ent_grant), .ext_grant(ext_grant), .gate_open(gate_open),
    .occupancy(occupancy), .full(full), .empty(empty), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: lane being served (0 none, 1 entrance, 2 exit), cycles it has been held,
  // closed cycles still owed, cars parked, lane served last.
  int m_lane = 0, m_served = 0, m_close_left = 0, m_occ = 0, m_last = 2, m_terr = 0;

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_lane = 0; m_served = 0; m_close_left = 0; m_occ = 0; m_last = 2; m_terr = 0;
    end else begin
      m_terr = 0;
      if (m_lane != 0) begin
        m_served++;
        if (pass) begin
          m_occ += (m_lane == 1) ? 1 : -1;
          m_last = m_lane; m_lane = 0; m_close_left = CC;
        end else if (m_served == TO) begin
          m_terr = 1; m_last = m_lane; m_lane = 0; m_close_left = CC;
        end
      end else if (m_close_left > 0) begin
        m_close_left--;
      end else begin
        bit e_ok, x_ok;
        e_ok = ent_req && (m_occ < CAP);
        x_ok = ext_req && (m_occ > 0);
        if (e_ok && x_ok) m_lane = (m_last == 1) ? 2 : 1;
        else if (e_ok)    m_lane = 1;
        else if (x_ok)    m_lane = 2;
        m_served = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("ent_grant",   ent_grant,   m_lane == 1);
    chk("ext_grant",   ext_grant,   m_lane == 2);
    chk("gate_open",   gate_open,   m_lane != 0);
    chk("timeout_err", timeout_err, m_terr);
    chk("occupancy",   occupancy,   m_occ);
    chk("full",        full,        m_occ == CAP);
    chk("empty",       empty,       m_occ == 0);
    chk("grant_excl",  ent_grant & ext_grant, 0);
  end

  task automatic wait_any(output int lane);
    lane = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ent_grant) begin lane = 1; break; end
      if (ext_grant) begin lane = 2; break; end
    end
    if (lane == 0) chk("grant_wait_expired", 0, 1);
  endtask

  task automatic do_pass();
    pass = 1'b1;
    @(negedge clk);
    pass = 1'b0;
  endtask

  initial begin
    int w, g;
    ent_req = 1'b1; ext_req = 1'b1; reset_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_outs",  {ent_grant, ext_grant, gate_open, timeout_err}, 0);
      chk("rst_occ",   occupancy, 0);
      chk("rst_empty", empty, 1);
    end
    ent_req = 1'b0; ext_req = 1'b0; reset_n = 1'b1;
    @(negedge clk);

    // single entry: grant for three cycles, pass on the third
    ent_req = 1'b1;
    @(negedge clk); chk("se_grant1", {ent_grant, gate_open}, 2'b11); ent_req = 1'b0;
    @(negedge clk); chk("se_grant2", {ent_grant, gate_open}, 2'b11);
    @(negedge clk); chk("se_grant3", {ent_grant, gate_open}, 2'b11); pass = 1'b1;
    @(negedge clk); pass = 1'b0;
    chk("se_occ", occupancy, 1);
    chk("se_closed", {ent_grant, gate_open}, 0);
    ext_req = 1'b1;
    for (int i = 0; i < CC; i++) begin
      @(negedge clk); chk("se_close_hold", ext_grant, 0);
    end
    @(negedge clk); chk("se_next_grant", ext_grant, 1);
    ext_req = 1'b0;
    do_pass();
    chk("se_exit_occ", occupancy, 0);

    // ties: lone eligible entrance first, then round-robin hands it to the exit
    ent_req = 1'b1; ext_req = 1'b1;
    wait_any(w); chk("tie_empty_ent", w, 1); do_pass(); chk("tie_occ1", occupancy, 1);
    wait_any(w); chk("tie_rr_ext", w, 2); do_pass(); chk("tie_occ0", occupancy, 0);
    ext_req = 1'b0;
    wait_any(w); chk("fill1", w, 1); do_pass();
    wait_any(w); chk("fill2", w, 1); do_pass();
    chk("occ_full", occupancy, 2);
    chk("full_flag", full, 1);

    // full lot: entrance held off indefinitely
    g = 0;
    repeat (50) begin @(negedge clk); if (ent_grant) g++; end
    chk("full_no_entry", g, 0);
    ext_req = 1'b1;
    wait_any(w); chk("full_exit", w, 2); ext_req = 1'b0; do_pass();
    chk("full_exit_occ", occupancy, 1);

    // timeout: entrance granted, nobody passes
    wait_any(w); chk("refill_ent", w, 1); ent_req = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("to_grant", ent_grant, k < TO);
      chk("to_err",   timeout_err, k == TO);
    end
    @(negedge clk); chk("to_err_pulse", timeout_err, 0);
    chk("to_occ", occupancy, 1);
    ent_req = 1'b1; ext_req = 1'b1;
    wait_any(w); chk("to_next_ext", w, 2);

    // reset during an exit service
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", {ent_grant, ext_grant, gate_open}, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_empty", empty, 1);
    reset_n = 1'b1; ent_req = 1'b0; ext_req = 1'b0;

    // random traffic, checked by the per-cycle compare against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ent_req = ($urandom % 3) != 0;
      ext_req = ($urandom % 3) != 0;
      pass    = ($urandom % 7) == 0;
      reset_n = ($urandom % 400) != 0;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
